rst_release_seq: RTL and testbench

Reset-release sequencer that sits directly downstream of the reset synchronizer in each clock domain. It consumes the synchronized domain reset and releases a set of per-block resets one at a time, after first enabling the domain clock gate, so that blocks leave reset in a fixed order with bounded inrush. It also serves software-requested soft resets of the whole domain and collapses all resets whenever the domain clock source reports unstable.

---
 rtl/rst_release_seq.sv | 174 +++++++++++++++++
 tb/tb_rst_release_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rst_release_seq.sv
// rst_release_seq
// Releases a domain's per-block resets one at a time after the domain clock
// gate is enabled. It also serves software soft-reset requests and collapses
// every reset whenever the domain clock source reports unstable.
//
// Soft-reset handshake: SW_RST_REQ is a level that is only looked at in DONE.
// The edge that accepts it produces a single-cycle SW_RST_ACK. A request seen
// in any other state is dropped rather than remembered. A request still high
// when DONE is reached again is accepted again.
module rst_release_seq #(
  parameter int unsigned NUM_OUT   = 3,
  parameter int unsigned STAGE_DLY = 16,
  parameter int unsigned HOLD_CYC  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLK_STABLE,
  input  logic               SW_RST_REQ,
  output logic               CLK_EN,
  output logic [NUM_OUT-1:0] STAGE_RST_N,
  output logic               SEQ_DONE,
  output logic               SW_RST_ACK,
  output logic [2:0]         dbg_state
);

  // The counter must hold the longer of the two phase lengths without wrapping.
  localparam int unsigned CNT_MAX = (STAGE_DLY > HOLD_CYC) ? STAGE_DLY : HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  typedef enum logic [2:0] {
    S_WAIT_CLK = 3'd0,
    S_CLK_ON   = 3'd1,
    S_RELEASE  = 3'd2,
    S_DONE     = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t             state_q,       state_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic [IDX_W-1:0]   idx_q,         idx_d;
  logic               clk_en_q,      clk_en_d;
  logic [NUM_OUT-1:0] stage_rst_n_q, stage_rst_n_d;
  logic               seq_done_q,    seq_done_d;
  logic               sw_rst_ack_q,  sw_rst_ack_d;

  // Register the state and every output. RST forces all of them back to the
  // fully-reset condition without waiting for a clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_WAIT_CLK;
      cnt_q         <= '0;
      idx_q         <= '0;
      clk_en_q      <= 1'b0;
      stage_rst_n_q <= '0;
      seq_done_q    <= 1'b0;
      sw_rst_ack_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      clk_en_q      <= clk_en_d;
      stage_rst_n_q <= stage_rst_n_d;
      seq_done_q    <= seq_done_d;
      sw_rst_ack_q  <= sw_rst_ack_d;
    end
  end

  // Next state and next outputs. Clock loss overrides everything else,
  // including a soft-reset request that arrives on the same edge.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    clk_en_d      = clk_en_q;
    stage_rst_n_d = stage_rst_n_q;
    seq_done_d    = seq_done_q;
    sw_rst_ack_d  = 1'b0;

    if (state_q != S_WAIT_CLK && !CLK_STABLE) begin
      state_d       = S_WAIT_CLK;
      cnt_d         = '0;
      idx_d         = '0;
      clk_en_d      = 1'b0;
      stage_rst_n_d = '0;
      seq_done_d    = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_CLK: begin
          if (CLK_STABLE) begin
            state_d  = S_CLK_ON;
            clk_en_d = 1'b1;
            cnt_d    = '0;
          end
        end

        S_CLK_ON: begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d            = '0;
            idx_d            = IDX_ONE;
            stage_rst_n_d[0] = 1'b1;
            if (NUM_OUT == 1) begin
              state_d    = S_DONE;
              seq_done_d = 1'b1;
            end else begin
              state_d = S_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d                = '0;
            stage_rst_n_d[idx_q] = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d    = S_DONE;
              seq_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_DONE: begin
          if (SW_RST_REQ) begin
            state_d       = S_HOLD;
            cnt_d         = '0;
            stage_rst_n_d = '0;
            seq_done_d    = 1'b0;
            sw_rst_ack_d  = 1'b1;
          end
        end

        S_HOLD: begin
          // Leaving HOLD looks exactly like a fresh clock enable, so the
          // release order and spacing match power-up.
          if (cnt_q == HOLD_LAST) begin
            state_d = S_CLK_ON;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d       = S_WAIT_CLK;
          cnt_d         = '0;
          idx_d         = '0;
          clk_en_d      = 1'b0;
          stage_rst_n_d = '0;
          seq_done_d    = 1'b0;
        end
      endcase
    end
  end

  assign CLK_EN      = clk_en_q;
  assign STAGE_RST_N = stage_rst_n_q;
  assign SEQ_DONE    = seq_done_q;
  assign SW_RST_ACK  = sw_rst_ack_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Testbench for rst_release_seq with the default parameters.
// Expected outputs come from the release-timing formulas and are queued
// before each edge. They are popped and compared at the following negedge.
module tb_rst_release_seq;

  localparam int NUM   = 3;
  localparam int SDLY  = 16;
  localparam int HOLD  = 4;
  localparam int W     = 6;  // {clk_en, stage_rst_n[2:0], seq_done, sw_rst_ack}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_stable = 1'b0;
  logic sw_rst_req = 1'b0;
  logic clk_en;
  logic [NUM-1:0] stage_rst_n;
  logic seq_done;
  logic sw_rst_ack;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  rst_release_seq #(
    .NUM_OUT  (NUM),
    .STAGE_DLY(SDLY),
    .HOLD_CYC (HOLD)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .CLK_STABLE (clk_stable),
    .SW_RST_REQ (sw_rst_req),
    .CLK_EN     (clk_en),
    .STAGE_RST_N(stage_rst_n),
    .SEQ_DONE   (seq_done),
    .SW_RST_ACK (sw_rst_ack),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = {clk_en, stage_rst_n, seq_done, sw_rst_ack};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued, actual en/rst_n/done/ack=%b", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: actual en/rst_n/done/ack=%b required %b (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  // ---------------- expected-value formulas ----------------
  // n = edges since the clock was enabled (E0 -> n=0).
  function automatic logic [W-1:0] pu_vec(input int n);
    int k;
    logic [NUM-1:0] t;
    k = n / SDLY;
    if (k > NUM) k = NUM;
    t = NUM'((1 << k) - 1);
    return {1'b1, t, (n >= NUM * SDLY), 1'b0};
  endfunction

  // n = edges since the soft-reset accept edge S (S -> n=0).
  function automatic logic [W-1:0] sr_vec(input int n);
    if (n < HOLD) return {1'b1, {NUM{1'b0}}, 1'b0, (n == 0)};
    return pu_vec(n - HOLD);
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: drive inputs, queue the expectation for the next
  // edge, then compare at the negedge that follows.
  task automatic step(input logic stable, input logic req, input logic [W-1:0] exp,
                      input string name, input int idx);
    clk_stable = stable;
    sw_rst_req = req;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("%s[%0d]", name, idx));
  endtask

  typedef struct {
    logic         stable;
    logic         req;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Records run from DONE: clock loss together with a request, requests
    // ignored in WAIT_CLK, then restart at E1 with a request ignored in CLK_ON.
    tbl[0] = '{stable: 1'b1, req: 1'b0, exp: 6'b1_111_1_0};
    tbl[1] = '{stable: 1'b0, req: 1'b1, exp: 6'b0_000_0_0};
    tbl[2] = '{stable: 1'b0, req: 1'b0, exp: 6'b0_000_0_0};
    tbl[3] = '{stable: 1'b0, req: 1'b1, exp: 6'b0_000_0_0};
    tbl[4] = '{stable: 1'b1, req: 1'b1, exp: 6'b1_000_0_0};
    tbl[5] = '{stable: 1'b1, req: 1'b1, exp: 6'b1_000_0_0};

    // Reset state: RST held for 5 cycles with a stable clock.
    rst = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, "reset", i);
    rst = 1'b0;

    // Power-up. A request at E0+20 must be ignored.
    for (int n = 0; n <= 60; n++) step(1'b1, (n == 20), pu_vec(n), "powerup", n);

    // One-cycle soft reset in DONE.
    for (int n = 0; n <= 60; n++) step(1'b1, (n == 0), sr_vec(n), "softrst", n);

    // Request held high: accepted at S, ignored across HOLD and the release,
    // then accepted again on the first edge back in DONE (S+53).
    for (int n = 0; n <= 52; n++) step(1'b1, 1'b1, sr_vec(n), "held_req", n);
    for (int n = 0; n <= 60; n++) step(1'b1, (n == 0), sr_vec(n), "held_reacc", n);

    // Table: simultaneous clock loss and request in DONE, then restart at E1.
    for (int i = 0; i < 6; i++) step(tbl[i].stable, tbl[i].req, tbl[i].exp, "table", i);
    for (int n = 2; n <= 39; n++) step(1'b1, 1'b0, pu_vec(n), "after_e1", n);

    // Clock loss at E1+40, then a full restart at E2.
    step(1'b0, 1'b0, '0, "clkloss", 40);
    step(1'b0, 1'b0, '0, "clkloss", 41);
    for (int n = 0; n <= 50; n++) step(1'b1, 1'b0, pu_vec(n), "restart_e2", n);

    // Clock loss while in DONE, then restart at E3.
    step(1'b0, 1'b0, '0, "done_loss", 0);
    for (int n = 0; n <= 25; n++) step(1'b1, 1'b0, pu_vec(n), "pre_async", n);

    // Async reset pulse between edges. Outputs must clear with no clock edge.
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back('0);
    check("async_rst");
    #1;
    rst = 1'b0;

    // The next edge is E4: a fresh sequence from WAIT_CLK.
    for (int n = 0; n <= 50; n++) step(1'b1, 1'b0, pu_vec(n), "after_async", n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
